// File: rtl/sg_seq_tx.sv
// sg_seq_tx: stimulus end of the sg1 serial acceptor link.
// Accepts a target-state command. It then steers the far-end acceptor to that
// state by driving the shortest bit sequence on i_out. A local copy of the
// acceptor FSM follows the far end every cycle.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// CTL_IDLE  | ready for a command; i_out holds IDLE_BIT
// CTL_SEND  | driving the planned path toward the latched target
module sg_seq_tx #(
    parameter logic IDLE_BIT  = 1'b0,
    parameter int   MAX_STEPS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_target,
    output logic       cmd_ready,
    output logic       i_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] mirror_state,
    output logic       at_a
);

    localparam int SW = $clog2(MAX_STEPS + 1);

    localparam logic [2:0] ST_A = 3'd0;
    localparam logic [2:0] ST_B = 3'd1;
    localparam logic [2:0] ST_C = 3'd2;
    localparam logic [2:0] ST_D = 3'd3;
    localparam logic [2:0] ST_E = 3'd4;

    typedef enum logic {
        CTL_IDLE = 1'b0,
        CTL_SEND = 1'b1
    } ctl_t;

    ctl_t            r_ctl;
    ctl_t            w_ctl_nxt;
    logic [2:0]      r_mirror;
    logic [2:0]      r_target;
    logic [2:0]      w_target_nxt;
    logic [SW-1:0]   r_steps;
    logic [SW-1:0]   w_steps_nxt;
    logic [SW-1:0]   w_steps_inc;
    logic            r_done;
    logic            r_err;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_bit;

    // Acceptor transition function; unused codes fall back to A.
    function automatic logic [2:0] f_nxt(input logic [2:0] m, input logic b);
        case (m)
            ST_A:    f_nxt = b ? ST_B : ST_A;
            ST_B:    f_nxt = b ? ST_C : ST_D;
            ST_C:    f_nxt = ST_B;
            ST_D:    f_nxt = ST_E;
            ST_E:    f_nxt = ST_E;
            default: f_nxt = ST_A;
        endcase
    endfunction

    // A reaches everything, B/C everything but A, D/E only E.
    function automatic logic f_reach(input logic [2:0] m, input logic [2:0] t);
        case (m)
            ST_A:       f_reach = (t <= ST_E);
            ST_B, ST_C: f_reach = (t != ST_A) && (t <= ST_E);
            default:    f_reach = (t == ST_E);
        endcase
    endfunction

    // First bit of the shortest path; C, D and E have a forced successor.
    function automatic logic f_step(input logic [2:0] m, input logic [2:0] t);
        case (m)
            ST_A:    f_step = (t != ST_A);
            ST_B:    f_step = (t == ST_B) || (t == ST_C);
            default: f_step = IDLE_BIT;
        endcase
    endfunction

    assign w_steps_inc = r_steps + SW'(1);

    // Next-state and output decode for the control FSM.
    always_comb begin
        w_ctl_nxt    = r_ctl;
        w_target_nxt = r_target;
        w_steps_nxt  = r_steps;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_bit        = IDLE_BIT;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        case (r_ctl)
            CTL_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_target_nxt = cmd_target;
                    w_steps_nxt  = '0;
                    w_ctl_nxt    = CTL_SEND;
                end
            end
            CTL_SEND: begin
                busy = 1'b1;
                if ((r_target > ST_E) || !f_reach(r_mirror, r_target)) begin
                    w_err_nxt = 1'b1;
                    w_ctl_nxt = CTL_IDLE;
                end else begin
                    w_bit       = f_step(r_mirror, r_target);
                    w_steps_nxt = w_steps_inc;
                    if (f_nxt(r_mirror, w_bit) == r_target) begin
                        w_done_nxt = 1'b1;
                        w_ctl_nxt  = CTL_IDLE;
                    end else if (w_steps_inc == SW'(MAX_STEPS)) begin
                        // Cannot happen with this planner; guards against a stuck path.
                        w_err_nxt = 1'b1;
                        w_ctl_nxt = CTL_IDLE;
                    end
                end
            end
            default: w_ctl_nxt = CTL_IDLE;
        endcase
    end

    // State registers; the mirror advances on every edge, including while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ctl    <= CTL_IDLE;
            r_mirror <= ST_A;
            r_target <= ST_A;
            r_steps  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ctl    <= w_ctl_nxt;
            r_mirror <= f_nxt(r_mirror, w_bit);
            r_target <= w_target_nxt;
            r_steps  <= w_steps_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    assign i_out        = w_bit;
    assign done         = r_done;
    assign err          = r_err;
    assign mirror_state = r_mirror;
    assign at_a         = (r_mirror == ST_A);

endmodule

// File: tb/tb_sg_seq_tx.sv
// Directed and randomized checks for sg_seq_tx, with a behavioural acceptor on i_out.
module tb_sg_seq_tx;

    localparam logic IB = 1'b0;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic [2:0] cmd_target;
    logic       cmd_ready;
    logic       i_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] mirror_state;
    logic       at_a;

    int errors = 0;
    int checks = 0;

    logic [2:0] acc;

    sg_seq_tx #(.IDLE_BIT(IB), .MAX_STEPS(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_target  (cmd_target),
        .cmd_ready   (cmd_ready),
        .i_out       (i_out),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mirror_state(mirror_state),
        .at_a        (at_a)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [2:0] tb_nxt(input logic [2:0] m, input logic b);
        logic [2:0] r;
        r = 3'd0;
        if (m == 3'd0) r = b ? 3'd1 : 3'd0;
        else if (m == 3'd1) r = b ? 3'd2 : 3'd3;
        else if (m == 3'd2) r = 3'd1;
        else if (m == 3'd3) r = 3'd4;
        else if (m == 3'd4) r = 3'd4;
        return r;
    endfunction

    // Reachability by exploring every bit choice for up to three steps.
    function automatic logic tb_reach(input logic [2:0] m, input logic [2:0] t);
        logic [7:0] cur;
        logic [7:0] nx;
        logic       hit;
        cur = 8'd0;
        cur[m] = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nx = 8'd0;
            for (int s = 0; s < 5; s++) begin
                if (cur[s]) begin
                    nx[tb_nxt(3'(s), 1'b0)] = 1'b1;
                    nx[tb_nxt(3'(s), 1'b1)] = 1'b1;
                end
            end
            cur = nx;
            if (t <= 3'd4 && cur[t]) hit = 1'b1;
        end
        return hit;
    endfunction

    // Reference acceptor driven by the DUT's bit stream.
    always @(posedge clock) begin
        if (reset) acc <= 3'd0;
        else       acc <= tb_nxt(acc, i_out);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = 3'd0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic send(input logic [2:0] t);
        cmd_valid  = 1'b1;
        cmd_target = t;
        tick;
        cmd_valid  = 1'b0;
    endtask

    logic       acc_now;
    logic [2:0] tgt_now;
    logic [2:0] tb_tgt;
    logic       tb_ok;
    int         nsend;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_target = 3'd0;
        tb_tgt = 3'd0; tb_ok = 1'b1; nsend = 0;

        // Test 1: reset values, then A->B.
        tick; tick;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_iout", i_out, IB);
        chk("rst_mirror", mirror_state, 0);
        chk("rst_at_a", at_a, 1);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b0;
        send(3'd1);
        chk("t1_busy", busy, 1);
        chk("t1_ready", cmd_ready, 0);
        chk("t1_bit", i_out, 1);
        tick;
        chk("t1_done", done, 1);
        chk("t1_mirror", mirror_state, 1);
        chk("t1_ready_done", cmd_ready, 1);
        tick;
        chk("t1_drift", mirror_state, 3);
        chk("t1_done_pulse", done, 0);

        // Test 2: A->E, then unreachable E->A.
        do_reset;
        send(3'd4);
        chk("t2_bit0", i_out, 1);
        tick;
        chk("t2_bit1", i_out, 0);
        tick;
        chk("t2_bit2", i_out, IB);
        chk("t2_busy", busy, 1);
        chk("t2_nodone", done, 0);
        tick;
        chk("t2_done", done, 1);
        chk("t2_mirror", mirror_state, 4);
        send(3'd0);
        chk("t2_err_bit", i_out, IB);
        chk("t2_err_busy", busy, 1);
        tick;
        chk("t2_err", err, 1);
        chk("t2_err_nodone", done, 0);
        chk("t2_err_mirror", mirror_state, 4);
        tick;
        chk("t2_err_pulse", err, 0);

        // Test 3: A->C, then back-to-back C->D accepted in the done cycle.
        do_reset;
        send(3'd2);
        chk("t3_bit0", i_out, 1);
        tick;
        chk("t3_bit1", i_out, 1);
        tick;
        chk("t3_done", done, 1);
        chk("t3_mirror", mirror_state, 2);
        send(3'd3);
        chk("t3_drift", mirror_state, 1);
        chk("t3_bit_d", i_out, 0);
        tick;
        chk("t3_done2", done, 1);
        chk("t3_mirror2", mirror_state, 3);

        // Test 4: A->A, then invalid code 6.
        do_reset;
        send(3'd0);
        chk("t4_bit", i_out, 0);
        chk("t4_at_a_send", at_a, 1);
        tick;
        chk("t4_done", done, 1);
        chk("t4_at_a", at_a, 1);
        send(3'd6);
        chk("t4_inv_bit", i_out, IB);
        tick;
        chk("t4_inv_err", err, 1);
        chk("t4_inv_nodone", done, 0);

        // Test 5: reset in the second SEND cycle aborts silently.
        do_reset;
        send(3'd4);
        tick;
        chk("t5_send2", busy, 1);
        reset = 1'b1;
        tick;
        chk("t5_mirror", mirror_state, 0);
        chk("t5_ready", cmd_ready, 1);
        chk("t5_busy", busy, 0);
        chk("t5_done", done, 0);
        chk("t5_err", err, 0);
        reset = 1'b0;
        tick;
        chk("t5_done_after", done, 0);
        chk("t5_err_after", err, 0);

        // Test 6: random commands against the reference acceptor.
        do_reset;
        for (int i = 0; i < 1000; i++) begin
            cmd_valid  = ($urandom_range(0, 3) == 0);
            cmd_target = 3'($urandom_range(0, 7));
            #1;
            acc_now = cmd_valid && cmd_ready;
            tgt_now = cmd_target;
            tick;
            chk("rnd_mirror", mirror_state, acc);
            if (done) begin
                chk("rnd_done_tgt", mirror_state, tb_tgt);
                chk("rnd_done_ok", tb_ok, 1);
                chk("rnd_done_len", (nsend <= 3), 1);
            end
            if (err) chk("rnd_err_reach", tb_ok, 0);
            if (done && err) chk("rnd_excl", 1, 0);
            if (acc_now) begin
                tb_tgt = tgt_now;
                tb_ok  = tb_reach(acc, tgt_now);
                nsend  = 0;
            end
            if (busy) nsend++;
        end
        cmd_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sg_seq_tx.md
Name: sg_seq_tx

Overview:
Transmitter side of the sg1-style serial acceptor protocol. It accepts a target-state command over a valid/ready handshake. It then drives the acceptor's single input bit `i_out` with the shortest bit sequence that steers the acceptor from its current state to the target. An internal mirror of the acceptor FSM (states A..E) tracks the far end every cycle, and the block reports completion or unreachability. It sits in the Segments benchmark set as the stimulus end paired with the acceptor.

Parameters:
IDLE_BIT, 0, value driven on `i_out` whenever no command is being sent.
MAX_STEPS, 4, defensive bound on bits sent per command before abort.

Ports:
clock  input  1  single clock, all state updates on posedge.
reset  input  1  synchronous, active-high.
cmd_valid  input  1  command offered.
cmd_target  input  3  target state code: A=0, B=1, C=2, D=3, E=4; codes 5..7 are invalid.
cmd_ready  output  1  high in IDLE; command accepted on a posedge with cmd_valid & cmd_ready.
i_out  output  1  bit to the acceptor; the acceptor samples it at each posedge.
busy  output  1  high in SEND.
done  output  1  one-cycle pulse: target reached.
err  output  1  one-cycle pulse: invalid or unreachable target, or step bound hit.
mirror_state  output  3  mirrored acceptor state (encoding as cmd_target).
at_a  output  1  mirror_state == A.

Behaviour:
- Mirror next-state function `nxt(m, b)`:
  - A: b ? B : A
  - B: b ? C : D
  - C: B
  - D: E
  - E: E
- Mirror update: every posedge, m <= nxt(m, i_out), in every control state.
- Reset: m=A, ctl=IDLE, target=A, steps=0, done=0, err=0.
- Reset outputs: cmd_ready=1, busy=0, i_out=IDLE_BIT, mirror_state=0, at_a=1.
- Reset asserted mid-SEND: abort immediately; no done or err pulse.
- Control FSM states: IDLE and SEND.
- IDLE:
  - cmd_ready=1, i_out=IDLE_BIT.
  - On accept: latch target, steps<=0, go to SEND.
  - cmd_ready is high even in a cycle where done or err is pulsing, so back-to-back commands are legal.
- SEND:
  - cmd_ready=0, busy=1.
  - `reach(m, T)`: A reaches all; B and C reach all except A; D and E reach only E.
  - If the target code is >4 or !reach(m, T): i_out=IDLE_BIT, err<=1, go to IDLE.
  - Otherwise i_out = `step(m, T)` (combinational from registered m and target):
    - m==A: (T != A)
    - m==B: (T==B || T==C)
    - m in {C, D, E}: IDLE_BIT
  - At the posedge: steps <= steps+1.
  - If nxt(m, i_out)==T: done<=1, go to IDLE.
  - Else if steps+1 == MAX_STEPS: err<=1, go to IDLE. This should never fire with the policy above; it is an assertion target.
- done and err are registered. Each is high only in the first IDLE cycle after the deciding edge, and they are mutually exclusive.
- Planning uses the mirror value after the accept edge, which includes that edge's IDLE_BIT. The acceptor moves every cycle, so B/C drift in IDLE is expected behaviour.
- A target equal to the current state still needs at least one bit:
  - A→A: one 0.
  - B→B: 1 then any.
  - E→E: any.
- Latency:
  - Accept at edge k; first bit driven in cycle k+1.
  - For a path of n bits, done is high in cycle k+n+1.
  - Maximum n = 3 (A→E, C→E).
- Error latency: err is high in cycle k+2; the mirror still advances on the abort-cycle IDLE_BIT.

Test Plan:
1. Reset, cmd_target=1 accepted at edge 1 → i_out=1 in cycle 2; done=1 and mirror_state=1 in cycle 3; idle 0 then drives mirror to 3 (D) in cycle 4.
2. Reset, cmd_target=4 → i_out sequence 1,0,IDLE_BIT over cycles 2–4; done in cycle 5; mirror_state=4. Next, cmd_target=0 → err pulse 2 cycles after accept, no done, mirror stays 4.
3. Reset, cmd_target=2 → bits 1,1, done with mirror=2. Command cmd_target=3 accepted in the done cycle (idle edge moves C→B) → i_out=0 next cycle, then done with mirror=3.
4. Reset, cmd_target=0 → single 0 bit, done after 1 step, at_a stays 1. cmd_target=6 → err pulse, i_out held at IDLE_BIT, no done.
5. cmd_target=4 from A; assert reset in the second SEND cycle → next cycle mirror=0, cmd_ready=1, busy=0, done=err=0.
6. Random commands, 1000 cycles, with a reference acceptor model on i_out → acceptor state == mirror_state every cycle; done only when mirror==latched target; err never fires for reachable valid targets.
